// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture controller.
// Holds the FSM encoding, the divider width and the sample-period table.
package la_pkg;

    localparam int unsigned DivWidth = 13;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPre      = 3'd1,
        StWaitTrig = 3'd2,
        StPost     = 3'd3,
        StHandoff  = 3'd4
    } la_state_e;

    // Sample period in clocks for each rate code.
    function automatic logic [DivWidth-1:0] rate_period(input logic [2:0] rate);
        logic [DivWidth-1:0] period;
        period = 13'd1;
        unique case (rate)
            3'd0: period = 13'd1;
            3'd1: period = 13'd2;
            3'd2: period = 13'd5;
            3'd3: period = 13'd10;
            3'd4: period = 13'd50;
            3'd5: period = 13'd100;
            3'd6: period = 13'd500;
            3'd7: period = 13'd5000;
            default: period = 13'd1;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/la_rate_tick.sv
// Sample-rate divider: emits a one-cycle tick every rate_period(rate) clocks.
// clear restarts the count so the first tick lands exactly one period later.
module la_rate_tick
    import la_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [2:0] rate,
    output logic       tick
);

    logic [DivWidth-1:0] div_q;

    assign tick = (div_q == (rate_period(rate) - DivWidth'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (clear || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivWidth'(1);
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: samples the probe bus into a circular BRAM window around a
// trigger, then holds stream_start to the UART streamer until it reports done.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned PRE_TRIG   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [2:0]            rate_sel,
    input  logic [DATA_WIDTH-1:0] probe_in,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  force_trig,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trigger_index,
    output logic [2:0]            rate_sel_lat,
    output logic                  capturing,
    output logic                  triggered,
    output logic                  stream_start,
    input  logic                  stream_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PreN  = ADDR_WIDTH'(PRE_TRIG);
    localparam logic [ADDR_WIDTH-1:0] PostN = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_WIDTH-1:0] One   = ADDR_WIDTH'(1);

    la_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] ptr_q, pre_cnt_q, post_cnt_q, trig_idx_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [2:0]            rate_lat_q;
    logic                  prev_match_q, triggered_q, wr_en_q, stream_start_q;

    logic tick, arm_go, sample_en, match, fire;

    la_rate_tick u_rate_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (arm_go),
        .rate  (rate_lat_q),
        .tick  (tick)
    );

    assign arm_go = arm && !abort && (state_q == StIdle);
    assign match  = (((probe_in ^ trig_value) & trig_mask) == '0);
    assign fire   = tick && !abort && (state_q == StWaitTrig) &&
                    ((match && !prev_match_q) || force_trig);

    // A zero-length post window means POST only passes through, writing nothing.
    assign sample_en = tick && !abort &&
                       ((state_q == StPre) || (state_q == StWaitTrig) ||
                        ((state_q == StPost) && (PostN != '0)));

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) state_d = (PRE_TRIG == 0) ? StWaitTrig : StPre;
                end
                StPre: begin
                    if (tick && ((pre_cnt_q + One) == PreN)) state_d = StWaitTrig;
                end
                StWaitTrig: begin
                    if (fire) state_d = StPost;
                end
                StPost: begin
                    if ((PostN == '0) || (tick && ((post_cnt_q + One) == PostN))) begin
                        state_d = StHandoff;
                    end
                end
                StHandoff: begin
                    if (stream_done) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            trig_idx_q     <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rate_lat_q     <= '0;
            prev_match_q   <= 1'b0;
            triggered_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            stream_start_q <= 1'b0;
        end else begin
            wr_en_q        <= sample_en;
            // Registered so it drops on the same edge that sees stream_done.
            stream_start_q <= (state_q == StHandoff) && !stream_done && !abort;
            if (arm_go) begin
                rate_lat_q   <= rate_sel;
                ptr_q        <= '0;
                pre_cnt_q    <= '0;
                prev_match_q <= 1'b1;
                triggered_q  <= 1'b0;
            end
            if (sample_en) begin
                wr_addr_q    <= ptr_q;
                wr_data_q    <= probe_in;
                ptr_q        <= ptr_q + One;
                prev_match_q <= match;
                if (state_q == StPre)  pre_cnt_q  <= pre_cnt_q + One;
                if (state_q == StPost) post_cnt_q <= post_cnt_q + One;
            end
            if (fire) begin
                trig_idx_q  <= ptr_q;
                triggered_q <= 1'b1;
                post_cnt_q  <= '0;
            end
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign trigger_index = trig_idx_q;
    assign rate_sel_lat  = rate_lat_q;
    assign triggered     = triggered_q;
    assign stream_start  = stream_start_q;
    assign capturing     = (state_q == StPre) || (state_q == StWaitTrig) ||
                           (state_q == StPost);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a 16-entry buffer and 4 pre-trigger samples.
// Expected values are hand-derived from the capture window arithmetic.
module tb_la_capture_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm, abort, force_trig, stream_done;
    logic [2:0]    rate_sel;
    logic [DW-1:0] probe_in, trig_mask, trig_value;
    logic          wr_en, capturing, triggered, stream_start;
    logic [AW-1:0] wr_addr, trigger_index;
    logic [DW-1:0] wr_data;
    logic [2:0]    rate_sel_lat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];

    la_capture_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PRE_TRIG   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .abort         (abort),
        .rate_sel      (rate_sel),
        .probe_in      (probe_in),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .force_trig    (force_trig),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .trigger_index (trigger_index),
        .rate_sel_lat  (rate_sel_lat),
        .capturing     (capturing),
        .triggered     (triggered),
        .stream_start  (stream_start),
        .stream_done   (stream_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // Rate-0 capture; probe = cycle number after arm, 0xA5 at tick trig_tick.
    task automatic count_capture(input int trig_tick, input int exp_idx,
                                 input int exp_writes, input int exp_last);
        bit done;
        int bad;
        int ss_cyc;
        logic [DW-1:0] exp_d;
        clear_log();
        rate_sel = 3'd0;
        probe_in = 8'h00;
        arm = 1'b1;
        step();
        arm = 1'b0;
        done = 1'b0;
        ss_cyc = 0;
        for (int n = 1; n < 80 && !done; n++) begin
            probe_in = (n == trig_tick) ? 8'hA5 : 8'(n);
            step();
            if (stream_start) begin
                done = 1'b1;
                ss_cyc = cyc;
            end
        end
        check("ss_reached", {31'd0, done}, 32'd1);
        check("trig_idx", {28'd0, trigger_index}, exp_idx);
        check("triggered", {31'd0, triggered}, 32'd1);
        check("n_writes", wa_q.size(), exp_writes);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            exp_d = (i == trig_tick - 1) ? 8'hA5 : 8'(i + 1);
            if (wa_q[i] !== 4'(i)) bad++;
            if (wd_q[i] !== exp_d) bad++;
        end
        check("wr_seq_bad", bad, 0);
        if (wa_q.size() > 0) begin
            check("last_addr", {28'd0, wa_q[$]}, exp_last);
            check("ss_after_last_wr", ss_cyc - wc_q[$], 1);
        end
    endtask

    task automatic handoff_finish();
        int n0;
        repeat (3) step();
        check("ss_held", {31'd0, stream_start}, 32'd1);
        n0 = wa_q.size();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_in_handoff", {30'd0, capturing, stream_start}, 32'd1);
        step();
        check("no_wr_after_arm", wa_q.size() - n0, 0);
        stream_done = 1'b1;
        step();
        stream_done = 1'b0;
        check("ss_drop", {31'd0, stream_start}, 32'd0);
        check("idle_after_done", {31'd0, capturing}, 32'd0);
    endtask

    initial begin
        int c1;
        int bad;
        bit done;
        rst_n       = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        force_trig  = 1'b0;
        stream_done = 1'b0;
        rate_sel    = 3'd0;
        probe_in    = 8'h00;
        trig_mask   = 8'hFF;
        trig_value  = 8'hA5;
        #2;
        check("rst_outs", {wr_en, capturing, triggered, stream_start, wr_addr, wr_data,
                           trigger_index}, 0);
        check("rst_rate_lat", {29'd0, rate_sel_lat}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Trigger at tick 10: window spans 21 writes, wrapping past address 15.
        count_capture(10, 9, 21, 4);
        handoff_finish();

        // Bus already matching at arm must not fire until it leaves and returns.
        clear_log();
        probe_in = 8'hA5;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            probe_in = (n == 9) ? 8'h00 : 8'hA5;
            if (n == 9) check("no_fire_on_held", {31'd0, triggered}, 32'd0);
            step();
        end
        check("reentry_fire", {31'd0, triggered}, 32'd1);
        check("reentry_idx", {28'd0, trigger_index}, 32'd9);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_post", {30'd0, wr_en, capturing}, 32'd0);
        check("abort_ss", {31'd0, stream_start}, 32'd0);

        // force_trig held through PRE only takes effect at the first WAIT_TRIG tick.
        clear_log();
        probe_in = 8'h00;
        force_trig = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (4) step();
        check("force_in_pre", {31'd0, triggered}, 32'd0);
        step();
        force_trig = 1'b0;
        check("force_fire", {31'd0, triggered}, 32'd1);
        check("force_idx", {28'd0, trigger_index}, 32'd4);
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            if (stream_start) done = 1'b1;
        end
        check("force_ss", {31'd0, done}, 32'd1);
        check("force_writes", wa_q.size(), 16);
        if (wa_q.size() > 0) check("force_last_addr", {28'd0, wa_q[$]}, 32'd15);
        handoff_finish();

        // Rate 3: one write every 10 clocks; mid-capture rate_sel changes ignored.
        clear_log();
        rate_sel = 3'd3;
        arm = 1'b1;
        step();
        arm = 1'b0;
        c1 = cyc;
        repeat (5) step();
        rate_sel = 3'd0;
        repeat (40) step();
        check("r3_rate_lat", {29'd0, rate_sel_lat}, 32'd3);
        check("r3_writes", wc_q.size(), 4);
        if (wc_q.size() > 0) check("r3_first", wc_q[0] - c1, 10);
        bad = 0;
        for (int i = 1; i < wc_q.size(); i++) if (wc_q[i] - wc_q[i-1] != 10) bad++;
        check("r3_gaps", bad, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("r3_abort", {31'd0, capturing}, 32'd0);

        // Late trigger so the pointer wraps before the trigger sample.
        count_capture(20, 3, 31, 14);
        handoff_finish();

        // Asynchronous reset in the middle of POST.
        clear_log();
        probe_in = 8'h00;
        force_trig = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (7) step();
        force_trig = 1'b0;
        check("pre_rst_post", {30'd0, capturing, triggered}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {wr_en, capturing, triggered, stream_start, wr_addr, wr_data,
                            trigger_index, rate_sel_lat}, 0);
        step();
        rst_n = 1'b1;
        step();
        count_capture(10, 9, 21, 4);
        handoff_finish();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
